// File: rtl/net_sequencer.sv
// rtl/net_sequencer.sv - sequencer for the 4-neuron recurrent datapath: load, sweep, settle, check, result
module net_sequencer #(
    parameter int W        = 32,
    parameter int MAX_ITER = 16,
    parameter int SETTLE   = 2,
    parameter int SEQ_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic [3:0]   sel,
    output logic [3:0]   upd_en,
    input  logic         dp_done,
    input  logic [W-1:0] dp_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_timeout,
    output logic [7:0]   iter_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SWEEP  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;

    localparam logic [7:0] ITER_LIMIT  = 8'(MAX_ITER);
    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [2:0] AFTER_SWEEP = (SETTLE == 0) ? S_CHECK : S_SETTLE;

    logic [2:0] state;
    logic [1:0] phase;
    logic [3:0] settle_cnt;
    logic       sweep_last;

    // In round-robin mode a sweep spans four cycles, one block per cycle.
    assign sweep_last = (SEQ_MODE == 0) || (phase == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            phase       <= 2'd0;
            settle_cnt  <= 4'd0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            iter_cnt    <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        iter_cnt <= 8'd0;
                    end
                end
                S_LOAD: begin
                    state <= S_SWEEP;
                    phase <= 2'd0;
                end
                S_SWEEP: begin
                    if (sweep_last) begin
                        if (iter_cnt != 8'hFF) iter_cnt <= iter_cnt + 8'd1;
                        settle_cnt <= 4'd0;
                        state      <= AFTER_SWEEP;
                    end else begin
                        phase <= phase + 2'd1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) state <= S_CHECK;
                    else settle_cnt <= settle_cnt + 4'd1;
                end
                S_CHECK: begin
                    // Convergence is tested first so it wins over the iteration limit.
                    if (dp_done) begin
                        res_data    <= dp_out;
                        res_timeout <= 1'b0;
                        state       <= S_RESULT;
                    end else if (iter_cnt == ITER_LIMIT) begin
                        res_data    <= dp_out;
                        res_timeout <= 1'b1;
                        state       <= S_RESULT;
                    end else begin
                        phase <= 2'd0;
                        state <= S_SWEEP;
                    end
                end
                S_RESULT: begin
                    if (res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        sel    = 4'b0000;
        upd_en = 4'b0000;
        case (state)
            S_LOAD: upd_en = 4'b1111;
            S_SWEEP: begin
                sel    = 4'b1111;
                upd_en = (SEQ_MODE == 0) ? 4'b1111 : (4'b0001 << phase);
            end
            S_SETTLE, S_CHECK: sel = 4'b1111;
            default: ;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_RESULT);

endmodule

// File: tb/tb_net_sequencer.sv
// tb/tb_net_sequencer.sv - directed vector bench for net_sequencer
module tb_net_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start, dp_done, res_ready;
    logic [31:0] dp_out;
    logic        busy, res_valid, res_timeout;
    logic [3:0]  sel, upd_en;
    logic [31:0] res_data;
    logic [7:0]  iter_cnt;

    logic        s1, dd1, rr1;
    logic [31:0] dpo1;
    logic        busy1, valid1, tmo1;
    logic [3:0]  sel1, upd1;
    logic [31:0] data1;
    logic [7:0]  iter1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    net_sequencer #(.W(32), .MAX_ITER(3), .SETTLE(2), .SEQ_MODE(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .sel(sel), .upd_en(upd_en),
        .dp_done(dp_done), .dp_out(dp_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_timeout(res_timeout), .iter_cnt(iter_cnt)
    );

    net_sequencer #(.W(32), .MAX_ITER(3), .SETTLE(1), .SEQ_MODE(1)) u_dut_rr (
        .clk(clk), .rst(rst), .start(s1), .busy(busy1), .sel(sel1), .upd_en(upd1),
        .dp_done(dd1), .dp_out(dpo1), .res_valid(valid1), .res_ready(rr1),
        .res_data(data1), .res_timeout(tmo1), .iter_cnt(iter1)
    );

    typedef struct {
        logic        start, done, ready;
        logic [31:0] dpo;
        logic        busy;
        logic [3:0]  sel, upd;
        logic        valid, tmo;
        logic [7:0]  iter;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] A = 32'h3F800000;
    localparam logic [31:0] B = 32'h40490FDB;
    localparam logic [31:0] C = 32'h40000000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input logic st, input logic dn, input logic rd, input logic [31:0] dpo,
                                input logic bz, input logic [3:0] sl, input logic [3:0] up,
                                input logic vl, input logic to, input logic [7:0] it,
                                input logic [31:0] dt);
        vec_t v;
        v.start = st; v.done = dn; v.ready = rd; v.dpo = dpo;
        v.busy = bz; v.sel = sl; v.upd = up; v.valid = vl; v.tmo = to; v.iter = it; v.data = dt;
        return v;
    endfunction

    logic [3:0] rr_upd[8];
    logic [3:0] rr_sel[8];

    initial begin
        start = 0; dp_done = 0; res_ready = 0; dp_out = 0;
        s1 = 0; dd1 = 1; rr1 = 0; dpo1 = 32'hBF800000;

        // Converge on sweep 1, handshake with a start in the same cycle, then a timeout run.
        tbl.push_back(mk(0,0,0,0, 0,4'h0,4'h0,0,0,0,0));
        tbl.push_back(mk(1,0,0,A, 0,4'h0,4'h0,0,0,0,0));
        tbl.push_back(mk(0,0,0,A, 1,4'h0,4'hF,0,0,0,0));
        tbl.push_back(mk(0,0,0,A, 1,4'hF,4'hF,0,0,0,0));
        tbl.push_back(mk(0,0,0,A, 1,4'hF,4'h0,0,0,1,0));
        tbl.push_back(mk(0,0,0,A, 1,4'hF,4'h0,0,0,1,0));
        tbl.push_back(mk(0,1,0,A, 1,4'hF,4'h0,0,0,1,0));
        tbl.push_back(mk(1,0,1,B, 1,4'h0,4'h0,1,0,1,A));
        tbl.push_back(mk(0,0,0,B, 0,4'h0,4'h0,0,0,1,A));
        tbl.push_back(mk(1,0,0,B, 0,4'h0,4'h0,0,0,1,A));
        tbl.push_back(mk(0,1,0,B, 1,4'h0,4'hF,0,0,0,A));
        tbl.push_back(mk(0,1,0,B, 1,4'hF,4'hF,0,0,0,A));
        tbl.push_back(mk(0,1,0,B, 1,4'hF,4'h0,0,0,1,A));
        tbl.push_back(mk(0,1,0,B, 1,4'hF,4'h0,0,0,1,A));
        tbl.push_back(mk(0,0,0,B, 1,4'hF,4'h0,0,0,1,A));
        tbl.push_back(mk(0,0,0,B, 1,4'hF,4'hF,0,0,1,A));
        tbl.push_back(mk(0,0,0,B, 1,4'hF,4'h0,0,0,2,A));
        tbl.push_back(mk(0,0,0,B, 1,4'hF,4'h0,0,0,2,A));
        tbl.push_back(mk(0,0,0,B, 1,4'hF,4'h0,0,0,2,A));
        tbl.push_back(mk(0,0,0,B, 1,4'hF,4'hF,0,0,2,A));
        tbl.push_back(mk(0,0,0,B, 1,4'hF,4'h0,0,0,3,A));
        tbl.push_back(mk(0,0,0,B, 1,4'hF,4'h0,0,0,3,A));
        tbl.push_back(mk(0,0,0,B, 1,4'hF,4'h0,0,0,3,A));
        tbl.push_back(mk(0,0,0,B, 1,4'h0,4'h0,1,1,3,B));
        tbl.push_back(mk(0,0,1,B, 1,4'h0,4'h0,1,1,3,B));
        tbl.push_back(mk(0,0,0,B, 0,4'h0,4'h0,0,1,3,B));

        repeat (3) @(negedge clk);
        rst = 1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start = tbl[i].start; dp_done = tbl[i].done; res_ready = tbl[i].ready; dp_out = tbl[i].dpo;
            chk($sformatf("v%0d busy", i),  32'(busy),        32'(tbl[i].busy));
            chk($sformatf("v%0d sel", i),   32'(sel),         32'(tbl[i].sel));
            chk($sformatf("v%0d upd", i),   32'(upd_en),      32'(tbl[i].upd));
            chk($sformatf("v%0d valid", i), 32'(res_valid),   32'(tbl[i].valid));
            chk($sformatf("v%0d tmo", i),   32'(res_timeout), 32'(tbl[i].tmo));
            chk($sformatf("v%0d iter", i),  32'(iter_cnt),    32'(tbl[i].iter));
            chk($sformatf("v%0d data", i),  res_data,         tbl[i].data);
        end

        // Convergence in the same CHECK where iter_cnt reaches MAX_ITER.
        @(negedge clk);
        start = 1; dp_done = 0; res_ready = 0; dp_out = C;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start = 0;
            dp_done = (k == 13);
        end
        @(negedge clk);
        dp_done = 0;
        chk("t6 valid", 32'(res_valid), 32'd1);
        chk("t6 tmo", 32'(res_timeout), 32'd0);
        chk("t6 iter", 32'(iter_cnt), 32'd3);
        chk("t6 data", res_data, C);

        // Back-pressured result with start pulses that must be ignored.
        for (int k = 0; k < 10; k++) begin
            start = k[0];
            dp_out = 32'h12345678;
            @(negedge clk);
            chk($sformatf("t4 valid %0d", k), 32'(res_valid), 32'd1);
            chk($sformatf("t4 busy %0d", k), 32'(busy), 32'd1);
            chk($sformatf("t4 data %0d", k), res_data, C);
        end
        start = 0; res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk("t4 busy after hs", 32'(busy), 32'd0);
        chk("t4 valid after hs", 32'(res_valid), 32'd0);
        chk("t4 data held", res_data, C);

        // Asynchronous reset in the middle of a sweep.
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        chk("t5 sweep upd", 32'(upd_en), 32'hF);
        #2 rst = 0;
        #1;
        chk("t5 busy", 32'(busy), 32'd0);
        chk("t5 sel", 32'(sel), 32'd0);
        chk("t5 upd", 32'(upd_en), 32'd0);
        chk("t5 valid", 32'(res_valid), 32'd0);
        chk("t5 tmo", 32'(res_timeout), 32'd0);
        chk("t5 iter", 32'(iter_cnt), 32'd0);
        chk("t5 data", res_data, 32'd0);
        @(negedge clk);
        rst = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("t5 load busy", 32'(busy), 32'd1);
        chk("t5 load sel", 32'(sel), 32'd0);
        chk("t5 load upd", 32'(upd_en), 32'hF);

        // Round-robin instance: one block per cycle, converges on sweep 1.
        rr_upd = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
        rr_sel = '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        s1 = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s1 = 0;
            chk($sformatf("t3 upd %0d", k), 32'(upd1), 32'(rr_upd[k]));
            chk($sformatf("t3 sel %0d", k), 32'(sel1), 32'(rr_sel[k]));
            chk($sformatf("t3 valid %0d", k), 32'(valid1), (k == 7) ? 32'd1 : 32'd0);
        end
        chk("t3 iter", 32'(iter1), 32'd1);
        chk("t3 data", data1, 32'hBF800000);
        chk("t3 tmo", 32'(tmo1), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
